cmlink_frame_scheduler: RTL and testbench



---
 rtl/cmlink_frame_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_cmlink_frame_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cmlink_frame_scheduler.sv
// rtl/cmlink_frame_scheduler.sv - Camera Link frame timing generator and live/test-pattern source arbiter
//
// Purpose: walks a programmable frame geometry (active/blank lines and pixels),
// drives frame/line/data valid strobes and fills every active pixel slot from
// either a live 24-bit valid/ready stream or an internal test pattern. The
// source is committed at frame start only, so a frame never mixes sources.
//
// Optional feature macro: CMLINK_SCHED_PATTERN_EN
//   defined     - test-pattern generator and frame counter present; i_src_sel honoured
//   not defined - pattern logic removed, every frame uses the live stream
//
// Ports:
//   i_clk, i_rst              pixel clock, asynchronous active-high reset
//   i_enable                  run request, sampled at frame boundaries
//   i_src_sel                 0 = live stream, 1 = test pattern (latched at frame start)
//   i_src_valid/o_src_ready   live pixel handshake (o_src_ready is combinational)
//   i_src_data[23:0]          live pixel {C, B, A}
//   o_fvld, o_lvld, o_dvld    registered frame/line/data valid strobes
//   o_porta/b/c[7:0]          registered pixel ports
//   o_busy                    high while the FSM is not idle
//   o_underflow_cnt[15:0]     saturating count of starved live slots

module cmlink_frame_scheduler #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BLANK  = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_src_sel,
  input  logic        i_src_valid,
  output logic        o_src_ready,
  input  logic [23:0] i_src_data,
  output logic        o_fvld,
  output logic        o_lvld,
  output logic        o_dvld,
  output logic [7:0]  o_porta,
  output logic [7:0]  o_portb,
  output logic [7:0]  o_portc,
  output logic        o_busy,
  output logic [15:0] o_underflow_cnt
);

  // Frame blank = blank tail of the last line plus the full vertical blank lines.
  localparam int unsigned FB_LEN = H_BLANK + V_BLANK * (H_ACTIVE + H_BLANK);

  localparam logic [CNT_W-1:0] X_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] X_BLK_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] X_FB_LAST  = CNT_W'(FB_LEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, LINE_ACT, LINE_BLK, FRAME_BLK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;   // pixel index in LINE_ACT, cycle index in the blank states
  logic [CNT_W-1:0] y_q, y_d;
  logic             src_q;

  logic             fvld_d, lvld_d, dvld_d, busy_d;
  logic [7:0]       porta_d, portb_d, portc_d;
  logic [15:0]      uf_d;

`ifdef CMLINK_SCHED_PATTERN_EN
  logic             src_d;
  logic [7:0]       fc_q, fc_d;
`else
  assign src_q = 1'b0;
  logic unused_src_sel;
  assign unused_src_sel = i_src_sel;
`endif

  // Next-state: geometry walk and frame-boundary commits.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef CMLINK_SCHED_PATTERN_EN
    src_d   = src_q;
    fc_d    = fc_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = LINE_ACT;
          x_d     = '0;
          y_d     = '0;
`ifdef CMLINK_SCHED_PATTERN_EN
          src_d   = i_src_sel;
`endif
        end
      end
      LINE_ACT: begin
        if (x_q == X_ACT_LAST) begin
          x_d     = '0;
          state_d = (y_q == Y_LAST) ? FRAME_BLK : LINE_BLK;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      LINE_BLK: begin
        if (x_q == X_BLK_LAST) begin
          x_d     = '0;
          y_d     = y_q + 1'b1;
          state_d = LINE_ACT;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      FRAME_BLK: begin
        if (x_q == X_FB_LAST) begin
          x_d = '0;
          y_d = '0;
          if (i_enable) begin
            state_d = LINE_ACT;
`ifdef CMLINK_SCHED_PATTERN_EN
            src_d   = i_src_sel;
            fc_d    = fc_q + 8'd1;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output staging: everything the transmitter sees is registered one cycle after the slot.
  always_comb begin
    fvld_d  = (state_q == LINE_ACT) || (state_q == LINE_BLK);
    lvld_d  = (state_q == LINE_ACT);
    dvld_d  = 1'b0;
    porta_d = 8'd0;
    portb_d = 8'd0;
    portc_d = 8'd0;
    uf_d    = o_underflow_cnt;
    busy_d  = (state_d != IDLE);
    if (state_q == LINE_ACT) begin
`ifdef CMLINK_SCHED_PATTERN_EN
      if (src_q) begin
        dvld_d  = 1'b1;
        porta_d = x_q[7:0];
        portb_d = y_q[7:0];
        portc_d = fc_q;
      end else
`endif
      if (i_src_valid) begin
        dvld_d  = 1'b1;
        porta_d = i_src_data[7:0];
        portb_d = i_src_data[15:8];
        portc_d = i_src_data[23:16];
      end else if (o_underflow_cnt != 16'hFFFF) begin
        // Starved slot is consumed, not retried.
        uf_d = o_underflow_cnt + 16'd1;
      end
    end
  end

  assign o_src_ready = (state_q == LINE_ACT) && !src_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      o_fvld          <= 1'b0;
      o_lvld          <= 1'b0;
      o_dvld          <= 1'b0;
      o_porta         <= 8'd0;
      o_portb         <= 8'd0;
      o_portc         <= 8'd0;
      o_busy          <= 1'b0;
      o_underflow_cnt <= 16'd0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      o_fvld          <= fvld_d;
      o_lvld          <= lvld_d;
      o_dvld          <= dvld_d;
      o_porta         <= porta_d;
      o_portb         <= portb_d;
      o_portc         <= portc_d;
      o_busy          <= busy_d;
      o_underflow_cnt <= uf_d;
    end
  end

`ifdef CMLINK_SCHED_PATTERN_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_q <= 1'b0;
      fc_q  <= 8'd0;
    end else begin
      src_q <= src_d;
      fc_q  <= fc_d;
    end
  end
`endif

endmodule

// File: tb/tb_cmlink_frame_scheduler.sv
// tb/tb_cmlink_frame_scheduler.sv - scoreboard bench for cmlink_frame_scheduler
module tb_cmlink_frame_scheduler;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int L  = HA + HB;
  localparam int P  = (VA + VB) * L;
  localparam int FV = VA * L - HB;

`ifdef CMLINK_SCHED_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, sel, valid;
  logic [23:0] data;
  logic        ready, fvld, lvld, dvld, busy;
  logic [7:0]  pa, pb, pc;
  logic [15:0] ufc;

  cmlink_frame_scheduler #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_src_sel(sel),
    .i_src_valid(valid), .o_src_ready(ready), .i_src_data(data),
    .o_fvld(fvld), .o_lvld(lvld), .o_dvld(dvld),
    .o_porta(pa), .o_portb(pb), .o_portc(pc),
    .o_busy(busy), .o_underflow_cnt(ufc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fvld, lvld, dvld;
    logic [7:0]  a, b, c;
    logic        busy, ready;
    logic [15:0] uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position t inside a (VA+VB)*L frame period.
  bit       m_run = 1'b0;
  int       m_t   = 0;
  bit       m_src = 1'b0;
  logic [7:0] m_fc = 8'd0;
  int       m_uf  = 0;

  function automatic bit in_act(int t);
    return ((t % L) < HA) && ((t / L) < VA);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   act;
    e = '0;
    if (rst) begin
      m_run = 0; m_t = 0; m_src = 0; m_fc = 0; m_uf = 0;
    end else begin
      act    = m_run && in_act(m_t);
      e.fvld = m_run && (m_t < FV);
      e.lvld = act;
      if (act) begin
        if (m_src) begin
          e.dvld = 1'b1;
          e.a = 8'(m_t % L);
          e.b = 8'(m_t / L);
          e.c = m_fc;
        end else if (valid) begin
          e.dvld = 1'b1;
          {e.c, e.b, e.a} = data;
        end else if (m_uf < 65535) begin
          m_uf++;
        end
      end
      if (!m_run) begin
        if (en) begin m_run = 1; m_t = 0; m_src = PAT & sel; end
      end else if (m_t == P - 1) begin
        if (en) begin m_t = 0; m_fc = m_fc + 8'd1; m_src = PAT & sel; end
        else m_run = 0;
      end else begin
        m_t++;
      end
      e.busy  = m_run;
      e.ready = m_run && in_act(m_t) && !m_src;
      e.uf    = 16'(m_uf);
    end
    exp_q.push_back(e);
  end

  // Monitor: compares every registered output cycle against the scoreboard.
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    g = {fvld, lvld, dvld, pa, pb, pc, busy, ready, ufc};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_bad++;
        $display("FAIL cycle_out t=%0t got f%0b l%0b d%0b a%h b%h c%h busy%0b rdy%0b uf%0d expected f%0b l%0b d%0b a%h b%h c%h busy%0b rdy%0b uf%0d",
                 $time, g.fvld, g.lvld, g.dvld, g.a, g.b, g.c, g.busy, g.ready, g.uf,
                 e.fvld, e.lvld, e.dvld, e.a, e.b, e.c, e.busy, e.ready, e.uf);
      end
    end
  end

  task automatic check_zero(string name);
    exp_t g;
    g = {fvld, lvld, dvld, pa, pb, pc, busy, ready, ufc};
    n_cmp++;
    if (g !== '0) begin
      n_bad++;
      $display("FAIL %s got %h required 0", name, g);
    end
  endtask

  // mode 0: valid=1 incrementing data; 1: random valid/sel; 2: random valid;
  // mode 3: starve slots 1 and 2 of line 0.
  task automatic run_cycles(int n, int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data = data + 24'd1;
      case (mode)
        0: valid = 1'b1;
        1: begin valid = ($urandom_range(3) != 0); sel = $urandom_range(1); data = 24'($urandom); end
        2: begin valid = ($urandom_range(3) != 0); data = 24'($urandom); end
        default: valid = !(m_run && (m_t / L) == 0 && ((m_t % L) == 1 || (m_t % L) == 2));
      endcase
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1; en = 1'b0; sel = 1'b0; valid = 1'b0; data = 24'd0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Pattern geometry, then live handshake with incrementing data.
    sel = 1'b1; en = 1'b1;
    run_cycles(3 * P, 0);
    sel = 1'b0;
    run_cycles(2 * P, 0);
    // Source selection toggling mid-frame.
    run_cycles(5 * P, 1);
    sel = 1'b0;
    run_cycles(3 * P, 2);
    // Directed underflow in line 0.
    run_cycles(2 * P, 3);

    // Drop enable during line 1.
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      valid = 1'b1;
      if (m_run && (m_t / L) == 1) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL wait_line1 timeout got 0 required 1"); end
    en = 1'b0;
    run_cycles(P + 5, 2);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_drop got %0b required 0", busy); end

    // Asynchronous reset in the middle of an active line.
    en = 1'b1; sel = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      valid = 1'b1;
      if (m_run && in_act(m_t) && m_t >= L) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL wait_active timeout got 0 required 1"); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    run_cycles(3 * P, 1);
    en = 1'b0;
    run_cycles(P + 4, 2);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
